// File: rtl/phy_rx_lane_align.sv
// Serial receiver: slides to COMMA alignment, locks after LOCK_COUNT aligned commas,
// then stripes data words round-robin over NUM_LANES outputs. Optional: LOCK_LOSS_EN.
module phy_rx_lane_align #(
    parameter int                WORD_W     = 8,
    parameter int                NUM_LANES  = 4,
    parameter logic [WORD_W-1:0] COMMA      = 8'hBC,
    parameter logic [WORD_W-1:0] IDLE       = 8'h7C,
    parameter int                LOCK_COUNT = 4
`ifdef LOCK_LOSS_EN
    ,
    parameter int                MAX_GAP    = 64
`endif
) (
    input  logic                        clk_32f,
    input  logic                        reset_L,
    input  logic                        data_in,
    output logic [NUM_LANES*WORD_W-1:0] data_out,
    output logic [NUM_LANES-1:0]        valid_out,
    output logic                        active,
    output logic                        comma_det
);

    localparam int                BIT_W     = $clog2(WORD_W);
    localparam int                LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [3:0]        LOCK_TGT  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH,
        SYNC,
        LOCKED
    } state_t;

    state_t                      state_q, state_d;
    logic [WORD_W-2:0]           shreg_q, shreg_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]                  comma_cnt_q, comma_cnt_d;
    logic [LANE_W-1:0]           lane_ptr_q, lane_ptr_d;
    logic [NUM_LANES*WORD_W-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]        valid_q, valid_d;
    logic                        active_q, active_d;
    logic                        comma_det_q, comma_det_d;

    logic [WORD_W-1:0]           shreg_nxt;
    logic                        boundary;
    logic                        is_comma;
    logic                        is_idle;
    logic                        lose_lock;

`ifdef LOCK_LOSS_EN
    localparam int               GAP_W    = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

    logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
`endif

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        shreg_nxt   = {shreg_q, data_in};
        boundary    = (bit_cnt_q == LAST_BIT);
        is_comma    = (shreg_nxt == COMMA);
        is_idle     = (shreg_nxt == IDLE);

        state_d     = state_q;
        shreg_d     = shreg_nxt[WORD_W-2:0];
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + BIT_W'(1);
        comma_cnt_d = comma_cnt_q;
        lane_ptr_d  = lane_ptr_q;
        data_d      = data_q;
        valid_d     = '0;
        comma_det_d = 1'b0;
        lose_lock   = 1'b0;

`ifdef LOCK_LOSS_EN
        lose_lock = (state_q == LOCKED) && boundary && !is_comma && (gap_cnt_q == GAP_LAST);
`endif

        case (state_q)
            SEARCH: begin
                // Bit-sliding: the hit edge defines the word boundary from here on.
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_det_d = 1'b1;
                    comma_cnt_d = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_d    = LOCKED;
                        lane_ptr_d = '0;
                    end else begin
                        state_d = SYNC;
                    end
                end
            end

            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_det_d = 1'b1;
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_d == LOCK_TGT) begin
                            state_d    = LOCKED;
                            lane_ptr_d = '0;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        lane_ptr_d  = '0;
                        comma_det_d = 1'b1;
                    end else if (lose_lock) begin
                        state_d     = SEARCH;
                        comma_cnt_d = '0;
                        lane_ptr_d  = '0;
                    end else if (!is_idle) begin
                        data_d[int'(lane_ptr_q)*WORD_W +: WORD_W] = shreg_nxt;
                        valid_d[lane_ptr_q] = 1'b1;
                        lane_ptr_d = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + LANE_W'(1);
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase

        active_d = (state_d == LOCKED);

`ifdef LOCK_LOSS_EN
        gap_cnt_d = gap_cnt_q;
        if ((state_q != LOCKED) || (boundary && is_comma) || lose_lock) begin
            gap_cnt_d = '0;
        end else if (boundary) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    // NOTE: the lane output registers are reset too; outputs must read zero while reset_L is low.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            lane_ptr_q  <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            active_q    <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            lane_ptr_q  <= lane_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            comma_det_q <= comma_det_d;
        end
    end

`ifdef LOCK_LOSS_EN
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign comma_det = comma_det_q;

endmodule

// File: tb/tb_phy_rx_lane_align.sv
// Bench for phy_rx_lane_align: directed word tables, hand sequences for reset and
// lock loss, and random word streams against a word-level reference model.
module tb_phy_rx_lane_align;

    localparam int          LANES   = 4;
    localparam logic [7:0]  COMMA_T = 8'hBC;
    localparam logic [7:0]  IDLE_T  = 8'h7C;
    localparam int          LOCK_T  = 4;
    localparam int          GAP_T   = 64;

    logic        clk_32f = 1'b0;
    logic        reset_L = 1'b0;
    logic        data_in = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        active;
    logic        comma_det;
    logic [37:0] obs;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_32f = ~clk_32f;

    phy_rx_lane_align #(
        .WORD_W    (8),
        .NUM_LANES (LANES),
        .COMMA     (COMMA_T),
        .IDLE      (IDLE_T),
        .LOCK_COUNT(LOCK_T)
    ) dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active),
        .comma_det(comma_det)
    );

    assign obs = {active, comma_det, valid_out, data_out};

`ifdef LOCK_LOSS_EN
    logic [31:0] g_data;
    logic [3:0]  g_valid;
    logic        g_active;
    logic        g_comma;

    phy_rx_lane_align #(
        .WORD_W    (8),
        .NUM_LANES (LANES),
        .COMMA     (COMMA_T),
        .IDLE      (IDLE_T),
        .LOCK_COUNT(LOCK_T),
        .MAX_GAP   (4)
    ) gap_dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (g_data),
        .valid_out(g_valid),
        .active   (g_active),
        .comma_det(g_comma)
    );
`endif

    typedef struct {
        logic [7:0]  word;
        logic [3:0]  v;
        logic [31:0] d;
        logic        act;
        logic        cd;
    } vec_t;

    vec_t        tbl[$];
    bit          rb[$];
    logic [37:0] exp_v[$];

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [7:0] w, logic [3:0] v, logic [31:0] d, logic a, logic c);
        vec_t r;
        r.word = w;
        r.v    = v;
        r.d    = d;
        r.act  = a;
        r.cd   = c;
        return r;
    endfunction

    // Called at a negedge; returns at the following negedge after one sampled bit.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        @(negedge clk_32f);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) send_bit(w[b]);
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        reset_L = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        check("reset", obs, 38'd0);
        reset_L = 1'b1;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            logic [7:0] w;
            w = tbl[i].word;
            for (int b = 7; b >= 0; b--) begin
                send_bit(w[b]);
                if (b != 0) check({name, "_mid"}, 38'({valid_out, comma_det}), 38'd0);
            end
            check(name, obs, {tbl[i].act, tbl[i].cd, tbl[i].v, tbl[i].d});
        end
    endtask

    task automatic load_basic();
        tbl.delete();
        for (int i = 0; i < 6; i++) tbl.push_back(mk(8'hBC, 4'h0, 32'h0, i >= 3, 1'b1));
        tbl.push_back(mk(8'hFF, 4'b0001, 32'h000000FF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hDD, 4'b0010, 32'h0000DDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hEE, 4'b0100, 32'h00EEDDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hCC, 4'b1000, 32'hCCEEDDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hBB, 4'b0001, 32'hCCEEDDBB, 1'b1, 1'b0));
        tbl.push_back(mk(8'h99, 4'b0010, 32'hCCEE99BB, 1'b1, 1'b0));
        tbl.push_back(mk(8'hAA, 4'b0100, 32'hCCAA99BB, 1'b1, 1'b0));
        tbl.push_back(mk(8'h88, 4'b1000, 32'h88AA99BB, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(8'hBC, 4'h0, 32'h88AA99BB, 1'b1, 1'b1));
    endtask

    // Word held in the receiver after edge t: the last 8 sampled bits, zeros before the first.
    function automatic logic [7:0] win(int t);
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = t - 7 + k;
            w = {w[6:0], (idx >= 0) ? rb[idx] : 1'b0};
        end
        return w;
    endfunction

    // Word-level reference: find a comma, walk whole words, record per-edge events.
    task automatic build_expect();
        int          n;
        int          t;
        int          cnt;
        int          ptr;
        int          gap;
        int          lock_t;
        bit          done;
        bit          lost;
        logic [7:0]  w;
        logic [3:0]  v;
        logic [31:0] d;
        bit          cm[];
        bit          ac[];
        int          wl[];
        logic [7:0]  ww[];

        n  = rb.size();
        cm = new[n];
        ac = new[n];
        wl = new[n];
        ww = new[n];
        for (int k = 0; k < n; k++) wl[k] = -1;
        t    = 0;
        done = 1'b0;
        while (!done) begin
            while (t < n && win(t) != COMMA_T) t++;
            if (t >= n) break;
            cm[t] = 1'b1;
            cnt   = 1;
            while (cnt < LOCK_T) begin
                t += 8;
                if (t >= n) break;
                if (win(t) == COMMA_T) begin
                    cm[t] = 1'b1;
                    cnt++;
                end else begin
                    break;
                end
            end
            if (t >= n) break;
            if (cnt < LOCK_T) begin
                t++;
                continue;
            end
            ptr    = 0;
            gap    = 0;
            lost   = 1'b0;
            lock_t = t;
            while (!lost) begin
                t += 8;
                if (t >= n) begin
                    done = 1'b1;
                    break;
                end
                w = win(t);
                if (w == COMMA_T) begin
                    cm[t] = 1'b1;
                    ptr   = 0;
                    gap   = 0;
                end else begin
`ifdef LOCK_LOSS_EN
                    if (gap + 1 == GAP_T) lost = 1'b1;
`endif
                    gap++;
                    if (!lost && w != IDLE_T) begin
                        wl[t] = ptr;
                        ww[t] = w;
                        ptr   = (ptr + 1) % LANES;
                    end
                end
            end
            for (int k = lock_t; k < t && k < n; k++) ac[k] = 1'b1;
            t++;
        end
        exp_v.delete();
        d = '0;
        for (int k = 0; k < n; k++) begin
            v = '0;
            if (wl[k] >= 0) begin
                d[wl[k]*8 +: 8] = ww[k];
                v[wl[k]]        = 1'b1;
            end
            exp_v.push_back({ac[k], cm[k], v, d});
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) rb.push_back(w[b]);
    endtask

    task automatic gen_stream();
        int r;
        rb.delete();
        repeat ($urandom_range(0, 7)) rb.push_back(1'($urandom_range(0, 1)));
        repeat (12) begin
            repeat ($urandom_range(2, 6)) push_word(COMMA_T);
            repeat ($urandom_range(1, 12)) begin
                r = $urandom_range(0, 9);
                if (r < 2)      push_word(COMMA_T);
                else if (r < 4) push_word(IDLE_T);
                else            push_word(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 3)) rb.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        @(negedge clk_32f);

        // Basic lock and striping.
        do_reset();
        load_basic();
        run_table("basic");

        // Three commas then data: no lock; four fresh commas then lock.
        do_reset();
        tbl.delete();
        for (int i = 0; i < 3; i++) tbl.push_back(mk(8'hBC, 4'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(8'hFF, 4'h0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(8'hBC, 4'h0, 32'h0, i == 3, 1'b1));
        tbl.push_back(mk(8'hFF, 4'b0001, 32'h000000FF, 1'b1, 1'b0));
        run_table("short_sync");

        // Bit-slip: three junk bits before the commas.
        do_reset();
        send_bit(1'b1); check("junk", obs, 38'd0);
        send_bit(1'b0); check("junk", obs, 38'd0);
        send_bit(1'b1); check("junk", obs, 38'd0);
        load_basic();
        run_table("slip");

        // Idle fill and frame reset on comma.
        tbl.delete();
        tbl.push_back(mk(8'hFF, 4'b0001, 32'h88AA99FF, 1'b1, 1'b0));
        tbl.push_back(mk(8'h7C, 4'b0000, 32'h88AA99FF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hDD, 4'b0010, 32'h88AADDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'h7C, 4'b0000, 32'h88AADDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'h7C, 4'b0000, 32'h88AADDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hEE, 4'b0100, 32'h88EEDDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hCC, 4'b1000, 32'hCCEEDDFF, 1'b1, 1'b0));
        tbl.push_back(mk(8'hBC, 4'b0000, 32'hCCEEDDFF, 1'b1, 1'b1));
        tbl.push_back(mk(8'h99, 4'b0001, 32'hCCEEDD99, 1'b1, 1'b0));
        run_table("idle");

        // Asynchronous reset mid-word while locked, then relock.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset_L = 1'b0;
        #1;
        check("async_reset", obs, 38'd0);
        @(negedge clk_32f);
        check("reset_hold", obs, 38'd0);
        reset_L = 1'b1;
        tbl.delete();
        for (int i = 0; i < 4; i++) tbl.push_back(mk(8'hBC, 4'h0, 32'h0, i == 3, 1'b1));
        tbl.push_back(mk(8'h5A, 4'b0001, 32'h0000005A, 1'b1, 1'b0));
        run_table("relock");

`ifdef LOCK_LOSS_EN
        // Lock loss on the MAX_GAP-th comma-free word (instance with MAX_GAP=4).
        do_reset();
        repeat (4) send_word(8'hBC);
        check("gap_lock", 38'(g_active), 38'd1);
        send_word(8'hFF);
        check("gap_w1", 38'({g_active, g_valid}), 38'(5'b1_0001));
        send_word(8'hFF);
        check("gap_w2", 38'({g_active, g_valid}), 38'(5'b1_0010));
        send_word(8'hFF);
        check("gap_w3", 38'({g_active, g_valid}), 38'(5'b1_0100));
        send_word(8'hFF);
        check("gap_loss", 38'({g_active, g_valid}), 38'(5'b0_0000));
        check("gap_data", 38'(g_data), 38'h00FFFFFF);
`endif

        // Random word streams against the reference model.
        for (int run = 0; run < 3; run++) begin
            do_reset();
            gen_stream();
            build_expect();
            for (int t = 0; t < rb.size(); t++) begin
                send_bit(rb[t]);
                check("random", obs, exp_v[t]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
